// File: rtl/capture_ctrl_pkg.sv
// Shared definitions for the camera capture controller.
//   state_e        : capture FSM states
//   NUM_PIXELS_DEF : default pixels per frame (160x120)
//   R_/G_/B_ MSB/LSB: bit positions kept when packing RGB565 down to RGB332
package capture_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StWaitSof,
    StCapture,
    StFinish
  } state_e;

  localparam int unsigned NUM_PIXELS_DEF = 19200;

  // RGB565 arrives as byte1 = R[4:0] G[5:3], byte2 = G[2:0] B[4:0].
  // RGB332 keeps the top 3/3/2 bits of R/G/B.
  localparam int unsigned R_MSB = 7;  // byte1
  localparam int unsigned R_LSB = 5;
  localparam int unsigned G_MSB = 2;  // byte1
  localparam int unsigned G_LSB = 0;
  localparam int unsigned B_MSB = 4;  // byte2
  localparam int unsigned B_LSB = 3;

endpackage

// File: rtl/capture_ctrl_rgb565_to_332.sv
// Combinational RGB565 -> RGB332 packer.
// Ports:
//   byte_hi : first camera byte of the pixel (R and high G bits)
//   byte_lo : second camera byte of the pixel (low G and B bits)
//   rgb332  : packed {R[2:0], G[2:0], B[1:0]}
module rgb565_to_332
  import capture_ctrl_pkg::*;
(
  input  logic [7:0] byte_hi,
  input  logic [7:0] byte_lo,
  output logic [7:0] rgb332
);

  assign rgb332 = {byte_hi[R_MSB:R_LSB], byte_hi[G_MSB:G_LSB], byte_lo[B_MSB:B_LSB]};

endmodule

// File: rtl/capture_ctrl.sv
// Camera frame capture controller: waits for a capture request, synchronises to
// VSYNC, assembles two-byte RGB565 pixels while HREF is high, and writes them
// as RGB332 into a framebuffer.
// Parameters:
//   NUM_PIXELS : pixels per frame
//   AW         : framebuffer address width
// Ports:
//   pclk        : pixel clock, all logic on rising edge
//   in_reset    : asynchronous active-high reset
//   inicio      : capture request (level, honoured only in IDLE)
//   vsync, href : camera sync signals
//   px_data     : camera byte bus
//   mem_px_addr : framebuffer write address
//   mem_px_data : RGB332 pixel
//   px_wr       : one-cycle write strobe per pixel
//   busy        : FSM not in IDLE
//   done        : one-cycle pulse at end of frame
//   frame_err   : sticky flag, frame pixel count differed from NUM_PIXELS
// Build option: define CAPTURE_CONTINUOUS_EN to re-arm after every frame
// instead of returning to IDLE.
module capture_ctrl
  import capture_ctrl_pkg::*;
#(
  parameter int unsigned NUM_PIXELS = NUM_PIXELS_DEF,
  parameter int unsigned AW         = 15
) (
  input  logic          pclk,
  input  logic          in_reset,
  input  logic          inicio,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    px_data,
  output logic [AW-1:0] mem_px_addr,
  output logic [7:0]    mem_px_data,
  output logic          px_wr,
  output logic          busy,
  output logic          done,
  output logic          frame_err
);

  // One extra bit so the counter can hold NUM_PIXELS itself.
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] PixMax = CW'(NUM_PIXELS);

  state_e        state_q, state_d;
  logic          vsync_q;
  logic          vs_rise, vs_fall;
  logic [CW-1:0] count_q;
  logic          phase_q;
  logic [7:0]    byte1_q;
  logic [7:0]    rgb332;
  logic          full;

  assign vs_rise = vsync & ~vsync_q;
  assign vs_fall = ~vsync & vsync_q;
  assign full    = (count_q >= PixMax);

  rgb565_to_332 u_pack (
    .byte_hi (byte1_q),
    .byte_lo (px_data),
    .rgb332  (rgb332)
  );

  // FSM state register
  always_ff @(posedge pclk or posedge in_reset) begin
    if (in_reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (inicio)  state_d = StArm;
      StArm:     if (vs_rise) state_d = StWaitSof;
      StWaitSof: if (vs_fall) state_d = StCapture;
      StCapture: if (vs_rise) state_d = StFinish;
`ifdef CAPTURE_CONTINUOUS_EN
      StFinish:               state_d = StWaitSof;
`else
      StFinish:               state_d = StIdle;
`endif
      default:                state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StFinish);
  end

  // Edge detect, byte assembly, pixel counter and write port
  always_ff @(posedge pclk or posedge in_reset) begin
    if (in_reset) begin
      vsync_q     <= 1'b0;
      count_q     <= '0;
      phase_q     <= 1'b0;
      byte1_q     <= 8'h00;
      mem_px_addr <= '0;
      mem_px_data <= 8'h00;
      px_wr       <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      vsync_q <= vsync;
      px_wr   <= 1'b0;

      if (state_q == StIdle && inicio) begin
        frame_err <= 1'b0;
      end

      if (state_q == StWaitSof && vs_fall) begin
        count_q <= '0;
        phase_q <= 1'b0;
      end

      if (state_q == StCapture) begin
        if (!href) begin
          // Odd trailing byte of a line is dropped here.
          phase_q <= 1'b0;
        end else if (!phase_q) begin
          byte1_q <= px_data;
          phase_q <= 1'b1;
        end else begin
          phase_q <= 1'b0;
          if (!full) begin
            mem_px_addr <= count_q[AW-1:0];
            mem_px_data <= rgb332;
            px_wr       <= 1'b1;
            count_q     <= count_q + CW'(1);
          end else begin
            // Overlong frame: drop the pixel, keep the counter saturated.
            frame_err <= 1'b1;
          end
        end
        if (vs_rise && !full) begin
          frame_err <= 1'b1;
        end
      end

`ifdef CAPTURE_CONTINUOUS_EN
      // Error is visible alongside done, then cleared for the next frame.
      if (state_q == StFinish) begin
        frame_err <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Self-checking bench for capture_ctrl with a small frame geometry
// (8 lines of 320 bytes) and random pixel bytes.
module tb_capture_ctrl;

  localparam int unsigned LineBytes  = 320;
  localparam int unsigned LinePx     = LineBytes / 2;
  localparam int unsigned FrameLines = 8;
  localparam int unsigned NumPx      = LinePx * FrameLines;
  localparam int unsigned Aw         = 11;
  localparam int unsigned LineGap    = 4;

  logic          pclk = 1'b0;
  logic          in_reset;
  logic          inicio;
  logic          vsync;
  logic          href;
  logic [7:0]    px_data;
  logic [Aw-1:0] mem_px_addr;
  logic [7:0]    mem_px_data;
  logic          px_wr;
  logic          busy;
  logic          done;
  logic          frame_err;

  capture_ctrl #(
    .NUM_PIXELS (NumPx),
    .AW         (Aw)
  ) dut (
    .pclk        (pclk),
    .in_reset    (in_reset),
    .inicio      (inicio),
    .vsync       (vsync),
    .href        (href),
    .px_data     (px_data),
    .mem_px_addr (mem_px_addr),
    .mem_px_data (mem_px_data),
    .px_wr       (px_wr),
    .busy        (busy),
    .done        (done),
    .frame_err   (frame_err)
  );

  always #5 pclk = ~pclk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference pixel conversion from decoded RGB565 fields.
  function automatic logic [7:0] to332(input logic [7:0] hi, input logic [7:0] lo);
    int unsigned pix, r5, g6, b5;
    pix = {16'h0000, hi, lo};
    r5  = pix / 2048;
    g6  = (pix / 32) % 64;
    b5  = pix % 32;
    return 8'((r5 / 4) * 32 + (g6 / 8) * 4 + b5 / 8);
  endfunction

  typedef struct {
    int unsigned cyc;
    int unsigned addr;
    logic [7:0]  data;
  } wr_t;

  wr_t         exp_q[$];
  int unsigned cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  // Model state for the frame being driven.
  bit          capturing = 1'b0;
  int unsigned model_cnt = 0;
  int unsigned model_pairs = 0;
  logic [7:0]  model_b1 = 8'h00;

  // Monitor
  int unsigned wr_cnt = 0;
  int unsigned done_cnt = 0;
  int unsigned last_addr = 0;
  logic        err_at_done = 1'b0;
  logic [7:0]  data_a0 = 8'h00;
  logic [7:0]  data_a1 = 8'h00;
  wr_t         mon_w;

  always @(negedge pclk) begin
    if (done) begin
      done_cnt++;
      err_at_done = frame_err;
    end
    if (px_wr) begin
      wr_cnt++;
      last_addr = 32'(mem_px_addr);
      if (mem_px_addr == 0) data_a0 = mem_px_data;
      if (mem_px_addr == 1) data_a1 = mem_px_data;
      if (exp_q.size() == 0) begin
        check_eq("spurious_wr", 32'(px_wr), 0);
      end else begin
        mon_w = exp_q.pop_front();
        check_eq("wr_cycle", cyc, mon_w.cyc);
        check_eq("wr_addr", 32'(mem_px_addr), mon_w.addr);
        check_eq("wr_data", 32'(mem_px_data), 32'(mon_w.data));
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      void'(exp_q.pop_front());
      check_eq("missing_wr", 32'(px_wr), 1);
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drive_byte(input int unsigned idx, input logic [7:0] b);
    tick();
    href    = 1'b1;
    px_data = b;
    if (idx % 2 == 0) begin
      model_b1 = b;
    end else begin
      model_pairs++;
      if (capturing && model_cnt < NumPx) begin
        exp_q.push_back('{cyc + 1, model_cnt, to332(model_b1, b)});
        model_cnt++;
      end
    end
  endtask

  task automatic send_line(input int unsigned nbytes, input bit rgb_first);
    logic [7:0] b;
    for (int unsigned i = 0; i < nbytes; i++) begin
      b = 8'($urandom);
      if (rgb_first) begin
        if (i == 0) b = 8'hF8;
        if (i == 1) b = 8'h1F;
        if (i == 2) b = 8'h07;
        if (i == 3) b = 8'hE0;
      end
      drive_byte(i, b);
    end
    tick();
    href = 1'b0;
    idle(LineGap);
  endtask

  task automatic pulse_inicio();
    inicio = 1'b1;
    tick();
    inicio = 1'b0;
  endtask

  // Produces the vsync rising edge that arms the capture.
  task automatic preamble();
    vsync = 1'b0;
    idle(2);
    vsync = 1'b1;
    idle(3);
  endtask

  // vsync fall, nlines lines (line odd_line gets one extra byte), vsync rise.
  task automatic frame(input int unsigned nlines, input int odd_line, input bit rgb);
    vsync       = 1'b0;
    capturing   = 1'b1;
    model_cnt   = 0;
    model_pairs = 0;
    idle(3);
    for (int l = 0; l < int'(nlines); l++) begin
      send_line((l == odd_line) ? LineBytes + 1 : LineBytes, rgb && (l == 0));
    end
    vsync = 1'b1;
    idle(4);
  endtask

  task automatic check_frame(input string tag, input int unsigned wr0, input int unsigned dn0);
    check_eq({tag, "_writes"}, wr_cnt - wr0, model_cnt);
    check_eq({tag, "_done"}, done_cnt - dn0, 1);
    check_eq({tag, "_err"}, 32'(err_at_done), 32'(model_pairs != NumPx));
    check_eq({tag, "_last_addr"}, last_addr, model_cnt - 1);
    check_eq({tag, "_pending"}, exp_q.size(), 0);
  endtask

  task automatic reset_mid_line();
    int unsigned wr0, dn0;
    pulse_inicio();
    preamble();
    vsync       = 1'b0;
    capturing   = 1'b1;
    model_cnt   = 0;
    model_pairs = 0;
    idle(3);
    for (int unsigned i = 0; i < 10; i++) drive_byte(i, 8'($urandom));
    tick();
    check_eq("pre_reset_wr", 32'(px_wr), 1);
    in_reset  = 1'b1;
    href      = 1'b0;
    capturing = 1'b0;
    exp_q.delete();
    #1;
    check_eq("rst_wr", 32'(px_wr), 0);
    check_eq("rst_addr", 32'(mem_px_addr), 0);
    check_eq("rst_data", 32'(mem_px_data), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_err", 32'(frame_err), 0);
    idle(2);
    in_reset = 1'b0;
    idle(2);
    // No request after reset: sync edges and data must be ignored.
    wr0 = wr_cnt;
    dn0 = done_cnt;
    vsync = 1'b1;
    idle(3);
    vsync = 1'b0;
    idle(3);
    for (int unsigned i = 0; i < 20; i++) drive_byte(i, 8'($urandom));
    tick();
    href  = 1'b0;
    vsync = 1'b1;
    idle(4);
    check_eq("idle_writes", wr_cnt - wr0, 0);
    check_eq("idle_done", done_cnt - dn0, 0);
    check_eq("idle_busy", 32'(busy), 0);
  endtask

  initial begin
    int unsigned wr0, dn0;
    in_reset = 1'b1;
    inicio   = 1'b0;
    vsync    = 1'b0;
    href     = 1'b0;
    px_data  = 8'h00;
    idle(3);
    check_eq("reset_wr", 32'(px_wr), 0);
    check_eq("reset_addr", 32'(mem_px_addr), 0);
    check_eq("reset_data", 32'(mem_px_data), 0);
    check_eq("reset_busy", 32'(busy), 0);
    check_eq("reset_done", 32'(done), 0);
    check_eq("reset_err", 32'(frame_err), 0);
    in_reset = 1'b0;
    idle(3);
    check_eq("post_reset_busy", 32'(busy), 0);

    pulse_inicio();
    check_eq("arm_busy", 32'(busy), 1);
    preamble();
    wr0 = wr_cnt;
    dn0 = done_cnt;
    frame(FrameLines, -1, 1'b1);
    check_frame("full", wr0, dn0);
    check_eq("rgb_f81f", 32'(data_a0), 32'h0000_00E3);
    check_eq("rgb_07e0", 32'(data_a1), 32'h0000_001C);

`ifndef CAPTURE_CONTINUOUS_EN
    idle(2);
    check_eq("full_idle_busy", 32'(busy), 0);

    // Short frame, then the next request clears the error.
    pulse_inicio();
    preamble();
    wr0 = wr_cnt;
    dn0 = done_cnt;
    frame(5, -1, 1'b0);
    check_frame("short", wr0, dn0);
    check_eq("short_err_sticky", 32'(frame_err), 1);
    pulse_inicio();
    check_eq("inicio_clears_err", 32'(frame_err), 0);

    // Long frame: writes stop at the last address.
    preamble();
    wr0 = wr_cnt;
    dn0 = done_cnt;
    frame(FrameLines + 1, -1, 1'b0);
    check_frame("long", wr0, dn0);
    check_eq("long_last_addr", last_addr, NumPx - 1);

    // One 321-byte line: odd byte dropped, following line realigned.
    pulse_inicio();
    preamble();
    wr0 = wr_cnt;
    dn0 = done_cnt;
    frame(FrameLines, 2, 1'b0);
    check_frame("odd", wr0, dn0);

    reset_mid_line();

    pulse_inicio();
    preamble();
    wr0 = wr_cnt;
    dn0 = done_cnt;
    frame(FrameLines, -1, 1'b0);
    check_frame("recover", wr0, dn0);
`else
    check_eq("cont_busy", 32'(busy), 1);
    check_eq("cont_err_clear0", 32'(frame_err), 0);
    // Second frame with no new request.
    wr0 = wr_cnt;
    dn0 = done_cnt;
    frame(5, -1, 1'b0);
    check_frame("cont_short", wr0, dn0);
    check_eq("cont_err_clear1", 32'(frame_err), 0);
    check_eq("cont_busy1", 32'(busy), 1);
    check_eq("cont_total_done", done_cnt, 2);

    in_reset = 1'b1;
    tick();
    in_reset = 1'b0;
    idle(2);
    reset_mid_line();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
